// File: rtl/sm_budget_pkg.sv
// Shared types, default widths and saturating helpers for the per-SM issue budget controller.
package sm_budget_pkg;

  localparam int unsigned DEF_NUM_SM    = 4;
  localparam int unsigned DEF_VOLT_W    = 8;
  localparam int unsigned DEF_ISSUE_W   = 5;
  localparam int unsigned DEF_BUDGET_W  = 12;
  localparam int unsigned DEF_SCALE     = 4;
  localparam int unsigned DEF_EPOCH_LEN = 64;

  // Working width for budget arithmetic; wide enough that products and sums never wrap.
  localparam int unsigned CALC_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [CALC_W-1:0] clamp_max(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] lim);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/sm_budget_lane.sv
// One SM lane: remaining-budget and throttle registers with load/deduct arithmetic.
// SM_BUDGET_CARRY_EN: roll unused budget into the next epoch, capped at twice the epoch budget.
module sm_budget_lane
  import sm_budget_pkg::*;
#(
  parameter int unsigned VOLT_W   = DEF_VOLT_W,
  parameter int unsigned ISSUE_W  = DEF_ISSUE_W,
  parameter int unsigned BUDGET_W = DEF_BUDGET_W,
  parameter int unsigned SCALE    = DEF_SCALE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_run,
  input  logic [VOLT_W-1:0]   i_voltage,
  input  logic                i_valid,
  input  logic [ISSUE_W-1:0]  i_issued,
  output logic [BUDGET_W-1:0] o_remaining,
  output logic                o_throttle
);

  localparam logic [CALC_W-1:0] MAX_BUDGET = CALC_W'((64'd1 << BUDGET_W) - 64'd1);

  logic [BUDGET_W-1:0] r_rem;
  logic                r_throttle;
  logic [CALC_W-1:0]   w_epoch_budget;
  logic [CALC_W-1:0]   w_base;
  logic [CALC_W-1:0]   w_ded;
  logic [CALC_W-1:0]   w_next;
  logic [BUDGET_W-1:0] w_next_rem;

  assign w_epoch_budget = clamp_max(CALC_W'(i_voltage) * CALC_W'(SCALE), MAX_BUDGET);
  assign w_ded          = i_valid ? CALC_W'(i_issued) : '0;

`ifdef SM_BUDGET_CARRY_EN
  logic [CALC_W-1:0] w_carry_sum;
  assign w_carry_sum = CALC_W'(r_rem) + w_epoch_budget;
  assign w_base      = clamp_max(clamp_max(w_carry_sum, w_epoch_budget << 1), MAX_BUDGET);
`else
  assign w_base      = w_epoch_budget;
`endif

  // LOAD charges this cycle's issue against the fresh epoch budget.
  always_comb begin
    w_next = CALC_W'(r_rem);
    if (i_load) begin
      w_next = sat_sub(w_base, w_ded);
    end else if (i_run) begin
      w_next = sat_sub(CALC_W'(r_rem), w_ded);
    end
  end

  assign w_next_rem = BUDGET_W'(w_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem      <= '0;
      r_throttle <= 1'b1;
    end else if (i_load || i_run) begin
      r_rem      <= w_next_rem;
      r_throttle <= (w_next_rem == '0);
    end
  end

  assign o_remaining = r_rem;
  assign o_throttle  = r_throttle;

endmodule

// File: rtl/sm_issue_budget_ctrl.sv
// Per-SM issue budget controller: epoch FSM, epoch counter and NUM_SM budget lanes.
// SM_BUDGET_CARRY_EN (lane option): unused budget rolls over into the next epoch.
module sm_issue_budget_ctrl
  import sm_budget_pkg::*;
#(
  parameter int unsigned NUM_SM    = DEF_NUM_SM,
  parameter int unsigned VOLT_W    = DEF_VOLT_W,
  parameter int unsigned ISSUE_W   = DEF_ISSUE_W,
  parameter int unsigned BUDGET_W  = DEF_BUDGET_W,
  parameter int unsigned SCALE     = DEF_SCALE,
  parameter int unsigned EPOCH_LEN = DEF_EPOCH_LEN,
  localparam int unsigned CNT_W    = $clog2(EPOCH_LEN)
) (
  input  logic                         clk_sm,
  input  logic                         rst_sm,
  input  logic [NUM_SM*VOLT_W-1:0]     sm_voltage,
  input  logic [NUM_SM-1:0]            sm_issue_valid,
  input  logic [NUM_SM*ISSUE_W-1:0]    sm_issued_this_cycle,
  output logic [NUM_SM*BUDGET_W-1:0]   sm_remaining,
  output logic [NUM_SM-1:0]            sm_throttle,
  output logic                         epoch_start,
  output logic [CNT_W-1:0]             epoch_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EPOCH_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_run;

  always_ff @(posedge clk_sm) begin
    if (rst_sm) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter restarts at 0 on every entry to LOAD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE: w_state_nxt = LOAD;
      LOAD: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = CNT_W'(1);
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = LOAD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load      = (r_state == LOAD);
  assign w_run       = (r_state == RUN);
  assign epoch_start = w_load;
  assign epoch_cnt   = r_cnt;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_lane
    sm_budget_lane #(
      .VOLT_W   (VOLT_W),
      .ISSUE_W  (ISSUE_W),
      .BUDGET_W (BUDGET_W),
      .SCALE    (SCALE)
    ) u_lane (
      .clk         (clk_sm),
      .rst         (rst_sm),
      .i_load      (w_load),
      .i_run       (w_run),
      .i_voltage   (sm_voltage[g*VOLT_W +: VOLT_W]),
      .i_valid     (sm_issue_valid[g]),
      .i_issued    (sm_issued_this_cycle[g*ISSUE_W +: ISSUE_W]),
      .o_remaining (sm_remaining[g*BUDGET_W +: BUDGET_W]),
      .o_throttle  (sm_throttle[g])
    );
  end

endmodule

// File: tb/tb_sm_issue_budget_ctrl.sv
// Bench for sm_issue_budget_ctrl: two instances (BUDGET_W 12 and 8) against an arithmetic epoch model.
module tb_sm_issue_budget_ctrl;

  localparam int EL = 8;

  logic        clk_sm = 1'b0;
  logic        rst_sm = 1'b1;
  logic [15:0] sm_voltage = '0;
  logic [1:0]  sm_issue_valid = '0;
  logic [9:0]  sm_issued_this_cycle = '0;

  logic [23:0] rem12;
  logic [15:0] rem8;
  logic [1:0]  thr12, thr8;
  logic        es12, es8;
  logic [2:0]  cnt12, cnt8;

  int vectors = 0;
  int miscompares = 0;

  // Model: k = cycle index since reset released; rem[w][lane], w=0 is 12-bit, w=1 is 8-bit.
  int k = 0;
  int m_rem [2][2];

  always #5 clk_sm = ~clk_sm;

  sm_issue_budget_ctrl #(
    .NUM_SM(2), .VOLT_W(8), .ISSUE_W(5), .BUDGET_W(12), .SCALE(4), .EPOCH_LEN(EL)
  ) u_dut12 (
    .clk_sm(clk_sm), .rst_sm(rst_sm), .sm_voltage(sm_voltage),
    .sm_issue_valid(sm_issue_valid), .sm_issued_this_cycle(sm_issued_this_cycle),
    .sm_remaining(rem12), .sm_throttle(thr12), .epoch_start(es12), .epoch_cnt(cnt12)
  );

  sm_issue_budget_ctrl #(
    .NUM_SM(2), .VOLT_W(8), .ISSUE_W(5), .BUDGET_W(8), .SCALE(4), .EPOCH_LEN(EL)
  ) u_dut8 (
    .clk_sm(clk_sm), .rst_sm(rst_sm), .sm_voltage(sm_voltage),
    .sm_issue_valid(sm_issue_valid), .sm_issued_this_cycle(sm_issued_this_cycle),
    .sm_remaining(rem8), .sm_throttle(thr8), .epoch_start(es8), .epoch_cnt(cnt8)
  );

  function automatic bit m_is_load();
    return (k >= 1) && (((k - 1) % EL) == 0);
  endfunction

  function automatic int m_cnt();
    return (k == 0) ? 0 : ((k - 1) % EL);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge();
    bit ld;
    bit rn;
    int lim, b, base, ded, v;
    if (rst_sm) begin
      k = 0;
      for (int w = 0; w < 2; w++) for (int i = 0; i < 2; i++) m_rem[w][i] = 0;
      return;
    end
    ld = m_is_load();
    rn = (k >= 1) && !ld;
    for (int w = 0; w < 2; w++) begin
      lim = (w == 0) ? 4095 : 255;
      for (int i = 0; i < 2; i++) begin
        v   = int'(sm_voltage[i*8 +: 8]);
        ded = sm_issue_valid[i] ? int'(sm_issued_this_cycle[i*5 +: 5]) : 0;
        b   = imin(v * 4, lim);
`ifdef SM_BUDGET_CARRY_EN
        base = imin(imin(m_rem[w][i] + b, 2 * b), lim);
`else
        base = b;
`endif
        if (ld) m_rem[w][i] = (base > ded) ? base - ded : 0;
        else if (rn) m_rem[w][i] = (m_rem[w][i] > ded) ? m_rem[w][i] - ded : 0;
      end
    end
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("es12", 32'(es12), 32'(m_is_load()));
    chk("es8", 32'(es8), 32'(m_is_load()));
    chk("cnt12", 32'(cnt12), 32'(m_cnt()));
    chk("cnt8", 32'(cnt8), 32'(m_cnt()));
    for (int i = 0; i < 2; i++) begin
      chk("rem12", 32'(rem12[i*12 +: 12]), 32'(m_rem[0][i]));
      chk("thr12", 32'(thr12[i]), 32'(m_rem[0][i] == 0));
      chk("rem8", 32'(rem8[i*8 +: 8]), 32'(m_rem[1][i]));
      chk("thr8", 32'(thr8[i]), 32'(m_rem[1][i] == 0));
    end
  endtask

  task automatic step(input logic rst, input int v0, input int v1, input logic [1:0] vld,
                      input int i0, input int i1);
    rst_sm               = rst;
    sm_voltage           = {8'(v1), 8'(v0)};
    sm_issue_valid       = vld;
    sm_issued_this_cycle = {5'(i1), 5'(i0)};
    @(posedge clk_sm);
    model_edge();
    @(negedge clk_sm);
    check_model();
  endtask

  task automatic go_load(input int v0, input int v1);
    int n = 0;
    while (!m_is_load() && n < 3 * EL) begin
      step(1'b0, v0, v1, 2'b00, 0, 0);
      n++;
    end
    chk("go_load_bound", 32'(m_is_load()), 32'd1);
  endtask

  task automatic go_cnt(input int target, input int v0, input int v1);
    int n = 0;
    while (!(m_cnt() == target && !m_is_load()) && n < 3 * EL) begin
      step(1'b0, v0, v1, 2'b00, 0, 0);
      n++;
    end
    chk("go_cnt_bound", 32'(m_cnt()), 32'(target));
  endtask

  initial begin
    int exp_collide;
    logic rr;
    @(negedge clk_sm);

    // Reset held three cycles
    repeat (3) step(1'b1, 0, 0, 2'b00, 0, 0);
    chk("rst_rem", 32'(rem12), 32'd0);
    chk("rst_thr", 32'(thr12), 32'd3);
    chk("rst_es", 32'(es12), 32'd0);

    // One IDLE cycle, then LOAD
    step(1'b0, 10, 0, 2'b00, 0, 0);
    chk("rel_es", 32'(es12), 32'd1);
    step(1'b0, 10, 0, 2'b00, 0, 0);
    chk("load_rem0", 32'(rem12[11:0]), 32'd40);
    chk("load_thr", 32'(thr12), 32'd2);

    // Deduct 2 for five RUN cycles
    repeat (5) step(1'b0, 10, 0, 2'b01, 2, 0);
    chk("ded_rem0", 32'(rem12[11:0]), 32'd30);
    chk("ded_rem1", 32'(rem12[23:12]), 32'd0);
    chk("ded_thr", 32'(thr12), 32'd2);

    // Issue on the LOAD cycle charges the new epoch
    go_load(10, 0);
`ifdef SM_BUDGET_CARRY_EN
    exp_collide = 65;
`else
    exp_collide = 35;
`endif
    step(1'b0, 10, 0, 2'b01, 5, 0);
    chk("collide_rem0", 32'(rem12[11:0]), 32'(exp_collide));
    step(1'b0, 10, 0, 2'b00, 31, 31);
    chk("invalid_rem0", 32'(rem12[11:0]), 32'(exp_collide));

    // Mid-epoch reset
    go_cnt(4, 10, 0);
    step(1'b1, 10, 0, 2'b11, 7, 7);
    chk("mid_rst_rem", 32'(rem12), 32'd0);
    chk("mid_rst_cnt", 32'(cnt12), 32'd0);
    chk("mid_rst_es", 32'(es12), 32'd0);
    step(1'b0, 1, 0, 2'b00, 0, 0);
    chk("mid_rst_load", 32'(es12), 32'd1);

    // Saturation at zero
    step(1'b0, 1, 0, 2'b00, 0, 0);
    chk("sat_load", 32'(rem12[11:0]), 32'd4);
    step(1'b0, 1, 0, 2'b01, 3, 0);
    chk("sat_1", 32'(rem12[11:0]), 32'd1);
    step(1'b0, 1, 0, 2'b01, 3, 0);
    chk("sat_0", 32'(rem12[11:0]), 32'd0);
    chk("sat_thr", 32'(thr12[0]), 32'd1);
    step(1'b0, 1, 0, 2'b01, 3, 0);
    chk("sat_hold", 32'(rem12[11:0]), 32'd0);

    // Clamp to the budget width
    go_load(255, 255);
    step(1'b0, 255, 255, 2'b00, 0, 0);
    chk("clamp8", 32'(rem8[7:0]), 32'd255);
    chk("noclamp12", 32'(rem12[11:0]), 32'd1020);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 63) == 0);
      step(rr,
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
